// File: rtl/fft_frame_pkg.sv
// Shared constants, state enums and sample packing for the audio frame feeder.
// Define SIGNED_SAMPLE_EN to convert offset-binary audio to two's complement before packing.
package fft_frame_pkg;

  localparam int FRAME_LEN = 2048;
  localparam int SAMPLE_W  = 8;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int ADDR_W    = IDX_W + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_e;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_FULL, BUF_STREAMING} buf_state_e;

  // Real part is the sample left-justified in 16 bits; imaginary part is zero.
  function automatic logic [DATA_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] v;
    v = s;
`ifdef SIGNED_SAMPLE_EN
    v[SAMPLE_W-1] = ~s[SAMPLE_W-1];
`else
    v = s;
`endif
    return {{(DATA_W/2){1'b0}}, v, {(DATA_W/2-SAMPLE_W){1'b0}}};
  endfunction

endpackage

// File: rtl/audio_frame_feeder_if.sv
// AXI-Stream link from the frame feeder to the FFT slave port.
interface audio_frame_feeder_if;
  import fft_frame_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_bram.sv
// Simple dual-port sample RAM holding both ping-pong frames; one-cycle registered read.
module frame_bram #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 8
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and read register carry no reset so the RAM maps onto block RAM;
  // consumers gate rdata with their own valid flag.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_feeder.sv
// Captures strobed audio into ping-pong frame buffers and streams whole frames to the FFT.
// Sample packing honours the SIGNED_SAMPLE_EN macro (see fft_frame_pkg).
module audio_frame_feeder
  import fft_frame_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic                audio_valid_in,
  audio_frame_feeder_if.master m_axis,
  output logic                overflow_out,
  output logic [15:0]         frames_sent_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  rd_state_e        state_q, state_d;
  buf_state_e       buf_q [2];
  buf_state_e       buf_d [2];
  logic             wr_buf_q, wr_buf_d;
  logic             rd_buf_q, rd_buf_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             tvalid_q, tvalid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      frames_q, frames_d;

  logic                we;
  logic [ADDR_W-1:0]   waddr, raddr;
  logic [SAMPLE_W-1:0] rdata;
  logic                fire, last_beat;

  assign fire      = tvalid_q && m_axis.tready;
  assign last_beat = (rd_idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    buf_d      = buf_q;
    rd_buf_d   = rd_buf_q;
    rd_idx_d   = rd_idx_q;
    tvalid_d   = tvalid_q;
    frames_d   = frames_q;
    raddr      = {rd_buf_q, rd_idx_q};
    wr_buf_d   = wr_buf_q;
    wr_idx_d   = wr_idx_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    waddr      = {wr_buf_q, wr_idx_q};

    unique case (state_q)
      RD_IDLE: begin
        if (buf_q[rd_buf_q] == BUF_FULL) begin
          buf_d[rd_buf_q] = BUF_STREAMING;
          state_d         = RD_PRIME;
        end
      end
      RD_PRIME: begin
        raddr    = {rd_buf_q, {IDX_W{1'b0}}};
        rd_idx_d = '0;
        tvalid_d = 1'b1;
        state_d  = RD_STREAM;
      end
      RD_STREAM: begin
        // Re-reading the held index while stalled keeps tdata stable; on a beat the
        // next index is fetched so it lands exactly when the current one is consumed.
        if (fire) begin
          if (last_beat) begin
            buf_d[rd_buf_q] = BUF_EMPTY;
            frames_d        = frames_q + 16'd1;
            tvalid_d        = 1'b0;
            rd_buf_d        = ~rd_buf_q;
            rd_idx_d        = '0;
            if (buf_q[~rd_buf_q] == BUF_FULL) begin
              buf_d[~rd_buf_q] = BUF_STREAMING;
              state_d          = RD_PRIME;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
            raddr    = {rd_buf_q, rd_idx_q + IDX_W'(1)};
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Write side sees the buffer state after any release above, so release wins.
    if (audio_valid_in) begin
      if (buf_d[wr_buf_q] inside {BUF_FULL, BUF_STREAMING}) begin
        overflow_d = 1'b1;
      end else begin
        we = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          buf_d[wr_buf_q] = BUF_FULL;
          wr_buf_d        = ~wr_buf_q;
          wr_idx_d        = '0;
        end else begin
          buf_d[wr_buf_q] = BUF_FILLING;
          wr_idx_d        = wr_idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= RD_IDLE;
      buf_q      <= '{BUF_EMPTY, BUF_EMPTY};
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      tvalid_q   <= tvalid_d;
      overflow_q <= overflow_d;
      frames_q   <= frames_d;
    end
  end

  frame_bram #(.ADDR_W(ADDR_W), .WIDTH(SAMPLE_W)) u_bram (
    .clk_in (clk_in),
    .we     (we),
    .waddr  (waddr),
    .wdata  (audio_in),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  assign m_axis.tvalid   = tvalid_q;
  assign m_axis.tlast    = tvalid_q && last_beat;
  assign m_axis.tdata    = tvalid_q ? pack_sample(rdata) : '0;
  assign overflow_out    = overflow_q;
  assign frames_sent_out = frames_q;

endmodule

// File: tb/tb_audio_frame_feeder.sv
// Scoreboard bench for audio_frame_feeder: a frame-level model queues expected beats,
// a monitor pops and compares every accepted beat and the status outputs.
module tb_audio_frame_feeder;
  import fft_frame_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        audio_valid_in = 1'b0;
  logic [7:0]  audio_in = 8'h00;
  logic        overflow_out;
  logic [15:0] frames_sent_out;

  audio_frame_feeder_if m_axis();

  audio_frame_feeder dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_in        (audio_in),
    .audio_valid_in  (audio_valid_in),
    .m_axis          (m_axis),
    .overflow_out    (overflow_out),
    .frames_sent_out (frames_sent_out)
  );

  initial forever #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  beat_t       exp_q[$];
  logic [7:0]  partial[$];
  int          pending = 0;
  logic [15:0] exp_frames = 16'd0;
  logic        exp_overflow = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Offset binary to two's complement is a subtraction of mid-scale.
  function automatic logic [31:0] exp_word(input logic [7:0] s);
    logic [7:0] r;
`ifdef SIGNED_SAMPLE_EN
    r = s - 8'd128;
`else
    r = s;
`endif
    return {16'h0000, r, 8'h00};
  endfunction

  // Two buffers: a sample is dropped only when two whole frames are still unsent.
  task automatic model_strobe(input logic [7:0] s);
    if (pending == 2) begin
      exp_overflow = 1'b1;
    end else begin
      partial.push_back(s);
      if (partial.size() == FRAME_LEN) begin
        for (int i = 0; i < FRAME_LEN; i++) begin
          beat_t b;
          b.data = exp_word(partial[i]);
          b.last = (i == FRAME_LEN - 1);
          exp_q.push_back(b);
        end
        partial.delete();
        pending++;
      end
    end
  endtask

  // One clock edge of stimulus: inputs at negedge+1, model at negedge+3 (after the monitor).
  task automatic step(input logic v, input logic [7:0] s, input logic r);
    @(negedge clk_in);
    #1;
    audio_valid_in = v;
    audio_in       = s;
    m_axis.tready  = r;
    #2;
    if (v) model_strobe(s);
    @(posedge clk_in);
    #1;
    audio_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #1;
    rst_in         = 1'b1;
    audio_valid_in = 1'b0;
    #2;
    exp_q.delete();
    partial.delete();
    pending      = 0;
    exp_frames   = 16'd0;
    exp_overflow = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tlast", m_axis.tlast, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_overflow", overflow_out, 0);
    check("rst_frames", frames_sent_out, 0);
  endtask

  task automatic drain(input bit rand_ready);
    int n = 0;
    while (exp_q.size() > 0 && n < 12000) begin
      step(1'b0, 8'h00, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    check("drain_complete", exp_q.size(), 0);
    repeat (4) step(1'b0, 8'h00, 1'b1);
  endtask

  // Monitor: scoreboard pops, hold-while-stalled and status outputs.
  initial begin
    logic        prev_stall = 1'b0;
    logic        mid_frame  = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    beat_t       b;
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_in) begin
        prev_stall = 1'b0;
        mid_frame  = 1'b0;
      end else begin
        check("frames_sent", frames_sent_out, exp_frames);
        check("overflow", overflow_out, exp_overflow);
        if (prev_stall) begin
          check("hold_tvalid", m_axis.tvalid, 1);
          check("hold_tdata", m_axis.tdata, prev_data);
          check("hold_tlast", m_axis.tlast, prev_last);
        end else if (mid_frame) begin
          check("tvalid_mid_frame", m_axis.tvalid, 1);
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got tdata 0x%08h with no beat expected at %0t",
                     m_axis.tdata, $time);
          end else begin
            b = exp_q.pop_front();
            check("beat_tdata", m_axis.tdata, b.data);
            check("beat_tlast", m_axis.tlast, b.last);
            if (b.last) begin
              pending--;
              exp_frames = exp_frames + 16'd1;
              mid_frame  = 1'b0;
            end else begin
              mid_frame = 1'b1;
            end
          end
        end
        prev_stall = m_axis.tvalid && !m_axis.tready;
        prev_data  = m_axis.tdata;
        prev_last  = m_axis.tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    m_axis.tready = 1'b0;
    repeat (2) @(posedge clk_in);
    do_reset();

    // 1: constant full-scale samples, no backpressure.
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'hFF, 1'b1);
    drain(1'b0);
    check("t1_frames", frames_sent_out, 16'd1);
    check("t1_overflow", overflow_out, 0);

    // 2: ramp with random backpressure.
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'(i), 1'($urandom_range(0, 1)));
    drain(1'b1);
    check("t2_frames", frames_sent_out, 16'd2);

    // 3: three frames of input while stalled; third frame is dropped.
    for (int i = 0; i < 3 * FRAME_LEN; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    check("t3_overflow_set", overflow_out, 1);
    drain(1'b0);
    check("t3_frames", frames_sent_out, 16'd4);

    // 4: last sample of B on the same edge as A's tlast handshake.
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < FRAME_LEN - 1; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < FRAME_LEN - 1; i++) step(1'b0, 8'h00, 1'b1);
    check("t4_a_last_pending", m_axis.tlast, 1);
    step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    lat = 0;
    while (!m_axis.tvalid && lat < 3) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    check("t4_b_start_within_3", m_axis.tvalid, 1);
    drain(1'b0);
    check("t4_frames", frames_sent_out, 16'd6);

    // 5: reset at beat 1000 of a streaming frame.
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    lat = 0;
    while (!m_axis.tvalid && lat < 4) begin
      step(1'b0, 8'h00, 1'b0);
      lat++;
    end
    check("t5_stream_started", m_axis.tvalid, 1);
    for (int i = 0; i < 1000; i++) step(1'b0, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < FRAME_LEN; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    drain(1'b0);
    check("t5_frames", frames_sent_out, 16'd1);
    check("t5_overflow", overflow_out, 0);

    // 6: packing of FF, 00, 80 (signed or unsigned depending on the build).
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    for (int i = 3; i < FRAME_LEN; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    drain(1'b1);
    check("t6_frames", frames_sent_out, 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
